// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Function : Arbitrates CPU, instruction-cache and DMA requests onto a single
//            SDRAM port and interleaves periodic refresh.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int REFRESH_PERIOD = 780,
    parameter int REFRESH_HOLD   = 12,
    parameter int TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [26:0] cpu_addr,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_di,
    output logic        cpu_done,
    output logic [31:0] cpu_do,
    input  logic        ic_req,
    input  logic [26:0] ic_addr,
    output logic        ic_done,
    input  logic        dma_req,
    input  logic [26:0] dma_addr,
    input  logic [1:0]  dma_cnt,
    output logic        dma_done,
    output logic        ram_req,
    output logic [26:0] ram_addr,
    output logic        ram_rnw,
    output logic        ram_iscache,
    output logic        ram_dma,
    output logic [1:0]  ram_dmacnt,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_di,
    output logic        ram_refresh,
    input  logic        ram_done,
    input  logic [31:0] ram_do32,
    output logic        busy,
    output logic        timeout_err
);

    localparam int c_RFSH_W = $clog2(REFRESH_PERIOD + 1);
    localparam int c_HOLD_W = $clog2(REFRESH_HOLD + 1);
    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [c_RFSH_W-1:0] c_RFSH_MAX = c_RFSH_W'(REFRESH_PERIOD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_END = c_HOLD_W'(REFRESH_HOLD - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_END = c_WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RFSH  = 2'd3;

    // Grantee encoding; c_G_NONE keeps the qualifier decodes low after reset.
    localparam logic [1:0] c_G_NONE = 2'd0;
    localparam logic [1:0] c_G_CPU  = 2'd1;
    localparam logic [1:0] c_G_IC   = 2'd2;
    localparam logic [1:0] c_G_DMA  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          r_gnt;
    logic                r_last_ic;
    logic [c_RFSH_W-1:0] r_rfsh_cnt;
    logic                r_rfsh_pend;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_timeout_err;
    logic                r_ram_req;
    logic                r_ram_refresh;
    logic [26:0]         r_ram_addr;
    logic                r_ram_rnw;
    logic [1:0]          r_ram_dmacnt;
    logic [3:0]          r_ram_be;
    logic [31:0]         r_ram_di;
    logic                r_cpu_done;
    logic                r_ic_done;
    logic                r_dma_done;
    logic [31:0]         r_cpu_do;

    logic w_expire;
    logic w_rfsh_due;
    logic w_serve_rfsh;
    logic w_cpu_win;
    logic w_ic_win;

    // An expiry in the same cycle as a request still wins, so it is folded in
    // here rather than waiting a cycle for the pending flag.
    assign w_expire     = (r_rfsh_cnt == c_RFSH_MAX);
    assign w_rfsh_due   = r_rfsh_pend || w_expire;
    assign w_serve_rfsh = (r_state == c_IDLE) && w_rfsh_due;

    assign w_cpu_win = cpu_req && (!ic_req || r_last_ic);
    assign w_ic_win  = ic_req && !w_cpu_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_gnt         <= c_G_NONE;
            r_last_ic     <= 1'b1;
            r_rfsh_cnt    <= '0;
            r_rfsh_pend   <= 1'b0;
            r_hold_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_ram_req     <= 1'b0;
            r_ram_refresh <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_rnw     <= 1'b0;
            r_ram_dmacnt  <= '0;
            r_ram_be      <= '0;
            r_ram_di      <= '0;
            r_cpu_done    <= 1'b0;
            r_ic_done     <= 1'b0;
            r_dma_done    <= 1'b0;
            r_cpu_do      <= '0;
        end else begin
            r_ram_req     <= 1'b0;
            r_ram_refresh <= 1'b0;
            r_cpu_done    <= 1'b0;
            r_ic_done     <= 1'b0;
            r_dma_done    <= 1'b0;

            if (w_expire) begin
                r_rfsh_cnt <= '0;
            end else begin
                r_rfsh_cnt <= r_rfsh_cnt + c_RFSH_W'(1);
            end

            if (w_serve_rfsh) begin
                r_rfsh_pend <= 1'b0;
            end else if (w_expire) begin
                r_rfsh_pend <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_rfsh_due) begin
                        r_ram_refresh <= 1'b1;
                        r_hold_cnt    <= '0;
                        r_state       <= c_RFSH;
                    end else if (dma_req) begin
                        r_gnt        <= c_G_DMA;
                        r_ram_addr   <= dma_addr;
                        r_ram_rnw    <= 1'b1;
                        r_ram_be     <= '0;
                        r_ram_di     <= '0;
                        r_ram_dmacnt <= dma_cnt;
                        r_ram_req    <= 1'b1;
                        r_state      <= c_ISSUE;
                    end else if (w_cpu_win) begin
                        r_gnt        <= c_G_CPU;
                        r_ram_addr   <= cpu_addr;
                        r_ram_rnw    <= cpu_rnw;
                        r_ram_be     <= cpu_be;
                        r_ram_di     <= cpu_di;
                        r_ram_dmacnt <= '0;
                        r_ram_req    <= 1'b1;
                        r_state      <= c_ISSUE;
                    end else if (w_ic_win) begin
                        r_gnt        <= c_G_IC;
                        r_ram_addr   <= ic_addr;
                        r_ram_rnw    <= 1'b1;
                        r_ram_be     <= '0;
                        r_ram_di     <= '0;
                        r_ram_dmacnt <= '0;
                        r_ram_req    <= 1'b1;
                        r_state      <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= c_WAIT;
                end
                c_WAIT: begin
                    if (ram_done) begin
                        case (r_gnt)
                            c_G_CPU: begin
                                r_cpu_done <= 1'b1;
                                r_last_ic  <= 1'b0;
                                if (r_ram_rnw) begin
                                    r_cpu_do <= ram_do32;
                                end
                            end
                            c_G_IC: begin
                                r_ic_done <= 1'b1;
                                r_last_ic <= 1'b1;
                            end
                            c_G_DMA: r_dma_done <= 1'b1;
                            default: ;
                        endcase
                        r_state <= c_IDLE;
                    end else if (r_wait_cnt == c_WAIT_END) begin
                        // Give up silently; the requester still holds req and
                        // is simply re-arbitrated from IDLE.
                        r_timeout_err <= 1'b1;
                        r_state       <= c_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                c_RFSH: begin
                    if (r_hold_cnt == c_HOLD_END) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign cpu_done    = r_cpu_done;
    assign cpu_do      = r_cpu_do;
    assign ic_done     = r_ic_done;
    assign dma_done    = r_dma_done;
    assign ram_req     = r_ram_req;
    assign ram_addr    = r_ram_addr;
    assign ram_rnw     = r_ram_rnw;
    assign ram_iscache = (r_gnt == c_G_IC);
    assign ram_dma     = (r_gnt == c_G_DMA);
    assign ram_dmacnt  = r_ram_dmacnt;
    assign ram_be      = r_ram_be;
    assign ram_di      = r_ram_di;
    assign ram_refresh = r_ram_refresh;
    assign busy        = (r_state != c_IDLE);
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbiter
// Function : Scoreboard bench for sdram_arbiter: directed requests push the
//            expected SDRAM transactions, a monitor pops and checks them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int c_PERIOD = 150;
    localparam int c_HOLD   = 12;
    localparam int c_TO     = 20;

    localparam int c_WHO_CPU = 0;
    localparam int c_WHO_IC  = 1;
    localparam int c_WHO_DMA = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_rnw = 1'b0;
    logic [26:0] cpu_addr = '0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_di = '0;
    logic        cpu_done;
    logic [31:0] cpu_do;
    logic        ic_req = 1'b0;
    logic [26:0] ic_addr = '0;
    logic        ic_done;
    logic        dma_req = 1'b0;
    logic [26:0] dma_addr = '0;
    logic [1:0]  dma_cnt = '0;
    logic        dma_done;
    logic        ram_req;
    logic [26:0] ram_addr;
    logic        ram_rnw, ram_iscache, ram_dma;
    logic [1:0]  ram_dmacnt;
    logic [3:0]  ram_be;
    logic [31:0] ram_di;
    logic        ram_refresh;
    logic        ram_done = 1'b0;
    logic [31:0] ram_do32 = '0;
    logic        busy, timeout_err;

    sdram_arbiter #(
        .REFRESH_PERIOD(c_PERIOD),
        .REFRESH_HOLD  (c_HOLD),
        .TIMEOUT       (c_TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_di(cpu_di), .cpu_done(cpu_done), .cpu_do(cpu_do),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_cnt(dma_cnt), .dma_done(dma_done),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_rnw(ram_rnw),
        .ram_iscache(ram_iscache), .ram_dma(ram_dma), .ram_dmacnt(ram_dmacnt),
        .ram_be(ram_be), .ram_di(ram_di), .ram_refresh(ram_refresh),
        .ram_done(ram_done), .ram_do32(ram_do32),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        int          who;
        logic [26:0] addr;
        logic        rnw;
        logic [3:0]  be;
        logic [31:0] di;
        logic [1:0]  cnt;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Monitor-owned observation state
    bit   outstanding = 1'b0;
    rec_t out_rec;
    int   dones_seen = 0;
    int   rfsh_seen = 0;
    int   last_req_cyc = 0;
    int   last_done_cyc = 0;
    int   last_rfsh_cyc = -1000;

    // Stimulus-owned SDRAM responder state
    int          resp_delay = 1;
    int          pend_cnt = 0;
    logic [26:0] resp_addr = '0;
    bit          kick_done = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] mem_word(input logic [26:0] a);
        return {5'b10110, a} ^ 32'h0F0F_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock step: also plays the requesters (drop req on done) and the SDRAM.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (cpu_done) cpu_req = 1'b0;
        if (ic_done)  ic_req  = 1'b0;
        if (dma_done) dma_req = 1'b0;
        ram_done = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                ram_done = 1'b1;
                ram_do32 = mem_word(resp_addr);
            end
        end
        if (ram_req && resp_delay > 0) begin
            pend_cnt  = resp_delay;
            resp_addr = ram_addr;
        end
        if (kick_done) begin
            ram_done  = 1'b1;
            ram_do32  = 32'hDEAD_BEEF;
            kick_done = 1'b0;
        end
    endtask

    task automatic push(input int who, input logic [26:0] a, input logic rnw,
                        input logic [3:0] be, input logic [31:0] di, input logic [1:0] cnt);
        rec_t r;
        r.who = who; r.addr = a; r.rnw = rnw; r.be = be; r.di = di; r.cnt = cnt;
        exp_q.push_back(r);
    endtask

    task automatic cpu_start(input logic rnw, input logic [26:0] a,
                             input logic [3:0] be, input logic [31:0] di);
        cpu_req = 1'b1; cpu_rnw = rnw; cpu_addr = a; cpu_be = be; cpu_di = di;
    endtask

    task automatic do_reset();
        cpu_req = 1'b0; ic_req = 1'b0; dma_req = 1'b0;
        pend_cnt = 0;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || outstanding || busy || cpu_req || ic_req || dma_req)
               && n < max) begin
            cycle();
            n++;
        end
        chk({name, "_completed_in_budget"}, (n < max), 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctrl"}, {cpu_done, ic_done, dma_done, ram_req, ram_rnw, ram_iscache,
                              ram_dma, ram_dmacnt, ram_be, ram_refresh, busy, timeout_err}, 0);
        chk({name, "_addr_di"}, {ram_addr, ram_di}, 0);
        chk({name, "_cpu_do"}, cpu_do, 0);
    endtask

    // Monitor: pops the scoreboard on every SDRAM request and checks done pulses.
    initial begin
        logic prev_req = 1'b0, prev_rfsh = 1'b0, prev_err = 1'b0;
        bit   rfsh_since_req = 1'b0;
        logic [2:0] dv;
        rec_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                outstanding = 1'b0;
            end else begin
                if (ram_req) begin
                    chk("ram_req_one_cycle", prev_req, 0);
                    if (rfsh_since_req) begin
                        chk("ram_req_after_refresh_hold", ((cyc - last_rfsh_cyc) > c_HOLD), 1);
                        rfsh_since_req = 1'b0;
                    end
                    last_req_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ram_req: got addr 0x%0h, expected no request", ram_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ram_addr", ram_addr, e.addr);
                        chk("ram_rnw", ram_rnw, e.rnw);
                        chk("ram_iscache", ram_iscache, (e.who == c_WHO_IC));
                        chk("ram_dma", ram_dma, (e.who == c_WHO_DMA));
                        if (e.who == c_WHO_DMA) chk("ram_dmacnt", ram_dmacnt, e.cnt);
                        if (e.who == c_WHO_CPU && !e.rnw) begin
                            chk("ram_be", ram_be, e.be);
                            chk("ram_di", ram_di, e.di);
                        end
                        out_rec = e;
                        outstanding = 1'b1;
                    end
                end
                if (ram_refresh) begin
                    chk("refresh_outside_transaction", outstanding, 0);
                    chk("ram_refresh_one_cycle", prev_rfsh, 0);
                    rfsh_seen++;
                    last_rfsh_cyc = cyc;
                    rfsh_since_req = 1'b1;
                end
                dv = {dma_done, ic_done, cpu_done};
                if (dv != 3'b000) begin
                    if (!outstanding) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_done: got done=%b, expected none", dv);
                    end else begin
                        chk("done_grantee", dv, (3'b001 << out_rec.who));
                        if (out_rec.who == c_WHO_CPU && out_rec.rnw)
                            chk("cpu_do", cpu_do, mem_word(out_rec.addr));
                    end
                    outstanding = 1'b0;
                    dones_seen++;
                    last_done_cyc = cyc;
                end
                if (timeout_err && !prev_err) outstanding = 1'b0;
            end
            prev_req  = ram_req;
            prev_rfsh = ram_refresh;
            prev_err  = timeout_err;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, n, t_done, t_rfsh;

        // Reset state
        cycle();
        chk_all_zero("reset_held");
        reset = 1'b0;
        cycle();
        chk_all_zero("after_reset");

        // Simultaneous CPU/cache after reset: last grant is cache, so CPU wins
        d0 = dones_seen;
        resp_delay = 2;
        cpu_start(1'b1, 27'h0000200, 4'h0, 32'h0);
        ic_req = 1'b1; ic_addr = 27'h0000300;
        push(c_WHO_CPU, 27'h0000200, 1'b1, 4'h0, 32'h0, 2'd0);
        push(c_WHO_IC,  27'h0000300, 1'b1, 4'h0, 32'h0, 2'd0);
        wait_idle("pair1", 60);
        chk("pair1_dones", dones_seen - d0, 2);

        // Lone CPU write, ram_done 5 cycles after ram_req, done one cycle later
        d0 = dones_seen;
        resp_delay = 5;
        cpu_start(1'b0, 27'h0000100, 4'h3, 32'hAABBCCDD);
        push(c_WHO_CPU, 27'h0000100, 1'b0, 4'h3, 32'hAABBCCDD, 2'd0);
        wait_idle("cpu_write", 60);
        chk("cpu_write_dones", dones_seen - d0, 1);
        chk("cpu_write_done_latency", last_done_cyc - last_req_cyc, 6);

        // CPU was granted last, so the cache now wins the pair
        d0 = dones_seen;
        resp_delay = 1;
        cpu_start(1'b1, 27'h0000400, 4'h0, 32'h0);
        ic_req = 1'b1; ic_addr = 27'h0000500;
        push(c_WHO_IC,  27'h0000500, 1'b1, 4'h0, 32'h0, 2'd0);
        push(c_WHO_CPU, 27'h0000400, 1'b1, 4'h0, 32'h0, 2'd0);
        wait_idle("pair2", 60);
        chk("pair2_dones", dones_seen - d0, 2);

        // DMA beats both; then CPU, then cache (last grant reset to cache)
        do_reset();
        d0 = dones_seen;
        resp_delay = 3;
        dma_req = 1'b1; dma_addr = 27'h0001000; dma_cnt = 2'd2;
        cpu_start(1'b1, 27'h0002000, 4'h0, 32'h0);
        ic_req = 1'b1; ic_addr = 27'h0003000;
        push(c_WHO_DMA, 27'h0001000, 1'b1, 4'h0, 32'h0, 2'd2);
        push(c_WHO_CPU, 27'h0002000, 1'b1, 4'h0, 32'h0, 2'd0);
        push(c_WHO_IC,  27'h0003000, 1'b1, 4'h0, 32'h0, 2'd0);
        wait_idle("dma_triple", 80);
        chk("dma_triple_dones", dones_seen - d0, 3);

        // Withheld ram_done: timeout, then the held request is retried and served
        do_reset();
        d0 = dones_seen;
        resp_delay = -1;
        cpu_start(1'b1, 27'h0004000, 4'h0, 32'h0);
        push(c_WHO_CPU, 27'h0004000, 1'b1, 4'h0, 32'h0, 2'd0);
        push(c_WHO_CPU, 27'h0004000, 1'b1, 4'h0, 32'h0, 2'd0);
        n = 0;
        while (!timeout_err && n < 3 * c_TO) begin
            cycle();
            n++;
        end
        chk("timeout_err_set", timeout_err, 1);
        chk("timeout_latency", cyc - last_req_cyc, c_TO + 1);
        chk("idle_after_timeout", busy, 0);
        chk("no_done_on_timeout", dones_seen - d0, 0);
        resp_delay = 3;
        wait_idle("timeout_retry", 60);
        chk("timeout_retry_dones", dones_seen - d0, 1);
        chk("timeout_err_sticky", timeout_err, 1);

        // Refresh expires while a read sits in WAIT
        do_reset();
        repeat (c_PERIOD - 6) cycle();
        r0 = rfsh_seen;
        resp_delay = 12;
        cpu_start(1'b1, 27'h0005000, 4'h0, 32'h0);
        push(c_WHO_CPU, 27'h0005000, 1'b1, 4'h0, 32'h0, 2'd0);
        n = 0;
        while (!cpu_done && n < 60) begin
            cycle();
            n++;
        end
        chk("refresh_txn_done_seen", cpu_done, 1);
        chk("no_refresh_before_done", rfsh_seen - r0, 0);
        t_done = cyc;
        cycle();
        chk("refresh_right_after_done", ram_refresh, 1);
        t_rfsh = cyc;
        chk("refresh_one_after_done", t_rfsh - t_done, 1);
        resp_delay = 2;
        cpu_start(1'b0, 27'h0006000, 4'hF, 32'h12345678);
        push(c_WHO_CPU, 27'h0006000, 1'b0, 4'hF, 32'h12345678, 2'd0);
        n = 0;
        while (!ram_req && n < 60) begin
            cycle();
            n++;
        end
        chk("req_after_refresh_seen", ram_req, 1);
        chk("req_after_refresh_gap", cyc - t_rfsh, c_HOLD + 1);
        wait_idle("refresh", 60);

        // Reset in WAIT abandons the read; a late ram_done must be ignored
        resp_delay = -1;
        cpu_start(1'b1, 27'h0007000, 4'h0, 32'h0);
        push(c_WHO_CPU, 27'h0007000, 1'b1, 4'h0, 32'h0, 2'd0);
        n = 0;
        while (!outstanding && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        chk("busy_in_wait", busy, 1);
        reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        chk_all_zero("async_reset");
        cycle();
        cycle();
        reset = 1'b0;
        d0 = dones_seen;
        kick_done = 1'b1;
        repeat (6) cycle();
        chk("no_stale_done", dones_seen - d0, 0);
        chk_all_zero("after_late_done");
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
